// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default delay constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    CORE      = 3'd2,
    RUN       = 3'd3,
    SOFT      = 3'd4
  } seq_state_t;

  localparam int DEF_LOCK_WAIT = 64;
  localparam int DEF_STAGE_DLY = 16;
  localparam int DEF_SOFT_LEN  = 32;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_level.sv
// Two-flop level synchronizer with asynchronous active-high clear to 0.
module sync_level (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: wait for a stable PLL lock, free the core, then the
// peripherals; supports a timed soft reset from RUN. State exposed on 'state'.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int LOCK_WAIT = DEF_LOCK_WAIT,
  parameter int STAGE_DLY = DEF_STAGE_DLY,
  parameter int SOFT_LEN  = DEF_SOFT_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       reset_core,
  output logic       reset_periph,
  output logic       reset_done,
  output logic [2:0] state
);

  localparam int CW = $clog2(max3(LOCK_WAIT, STAGE_DLY, SOFT_LEN) + 1);
  localparam logic [CW-1:0] LW_LAST = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] SD_LAST = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] SL_LAST = CW'(SOFT_LEN - 1);

  logic          lock_s;
  seq_state_t    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          core_n, periph_n, done_n;

  sync_level u_lock_sync (
    .clk (clk),
    .clr (reset),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      reset_core   <= 1'b1;
      reset_periph <= 1'b1;
      reset_done   <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      reset_core   <= core_n;
      reset_periph <= periph_n;
      reset_done   <= done_n;
    end
  end

  // Every terminal count exits the state with the counter cleared, so it never wraps.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_s) state_n = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_q == LW_LAST) begin
          state_n = CORE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      CORE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_q == SD_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s)             state_n = WAIT_LOCK;
        else if (soft_reset_req) state_n = SOFT;
      end
      SOFT: begin
        if (cnt_q == SL_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are a pure function of the next state, which keeps the release
  // order and reset_done == !reset_periph true by construction.
  always_comb begin
    core_n   = !((state_n == CORE) || (state_n == RUN));
    periph_n = (state_n != RUN);
    done_n   = (state_n == RUN);
  end

  assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_WAIT=8, STAGE_DLY=4, SOFT_LEN=6.
module tb_reset_sequencer;

  localparam int LW = 8;
  localparam int SD = 4;
  localparam int SL = 6;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CORE   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_SOFT   = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       reset_core;
  logic       reset_periph;
  logic       reset_done;
  logic [2:0] state;

  int tests    = 0;
  int failures = 0;

  reset_sequencer #(.LOCK_WAIT(LW), .STAGE_DLY(SD), .SOFT_LEN(SL)) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .reset_core     (reset_core),
    .reset_periph   (reset_periph),
    .reset_done     (reset_done),
    .state          (state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic c, input logic p,
                            input logic d, input logic [2:0] s);
    check({tag, ".core"},   32'(reset_core),   32'(c));
    check({tag, ".periph"}, 32'(reset_periph), 32'(p));
    check({tag, ".done"},   32'(reset_done),   32'(d));
    check({tag, ".state"},  32'(state),        32'(s));
  endtask

  // Release-order invariants, sampled on every falling edge.
  always @(negedge clk) begin
    tests++;
    assert (!(reset_periph === 1'b0 && reset_core === 1'b1) && (reset_done === !reset_periph))
    else begin
      failures++;
      $error("FAIL invariant: observed core=%b periph=%b done=%b required order/done", reset_core,
             reset_periph, reset_done);
    end
  end

  initial begin
    reset          = 1'b1;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    step(3);
    check_outs("in_reset", 1'b1, 1'b1, 1'b0, S_WAIT);

    // Power-up: lock held, release reset; lock_s rises after two edges.
    pll_locked = 1'b1;
    reset      = 1'b0;
    step(2);
    check_outs("pwr_sync", 1'b1, 1'b1, 1'b0, S_WAIT);
    step(1);
    check_outs("pwr_settle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(LW - 1);
    check_outs("pwr_settle_last", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(1);
    check_outs("pwr_core", 1'b0, 1'b1, 1'b0, S_CORE);
    step(SD - 1);
    check_outs("pwr_core_last", 1'b0, 1'b1, 1'b0, S_CORE);
    step(1);
    check_outs("pwr_run", 1'b0, 1'b0, 1'b1, S_RUN);

    // Soft reset, with a second ignored request inside SOFT.
    step(2);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_outs("soft_enter", 1'b1, 1'b1, 1'b0, S_SOFT);
    step(2);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_outs("soft_second_req", 1'b1, 1'b1, 1'b0, S_SOFT);
    step(SL - 4);
    check_outs("soft_last", 1'b1, 1'b1, 1'b0, S_SOFT);
    step(1);
    check_outs("soft_exit", 1'b1, 1'b1, 1'b0, S_WAIT);
    step(1);
    check_outs("soft_settle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(LW);
    check_outs("soft_core", 1'b0, 1'b1, 1'b0, S_CORE);
    step(SD);
    check_outs("soft_run", 1'b0, 1'b0, 1'b1, S_RUN);

    // Lock loss and soft request seen by the FSM in the same RUN cycle.
    pll_locked = 1'b0;
    step(2);
    check_outs("simul_pre", 1'b0, 1'b0, 1'b1, S_RUN);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_outs("simul_wait", 1'b1, 1'b1, 1'b0, S_WAIT);
    step(5);
    check_outs("simul_hold", 1'b1, 1'b1, 1'b0, S_WAIT);
    pll_locked = 1'b1;
    step(2);
    check_outs("simul_relock_sync", 1'b1, 1'b1, 1'b0, S_WAIT);
    step(1);
    check_outs("simul_settle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(LW);
    check_outs("simul_core", 1'b0, 1'b1, 1'b0, S_CORE);
    step(SD);
    check_outs("simul_run", 1'b0, 1'b0, 1'b1, S_RUN);

    // Lock glitch of 3 cycles, seen by the FSM at SETTLE count 5.
    pll_locked = 1'b0;
    step(3);
    check_outs("glitch_wait", 1'b1, 1'b1, 1'b0, S_WAIT);
    pll_locked = 1'b1;
    step(3);
    check_outs("glitch_settle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(3);
    pll_locked = 1'b0;
    step(2);
    check_outs("glitch_cnt5", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(1);
    check_outs("glitch_drop", 1'b1, 1'b1, 1'b0, S_WAIT);
    pll_locked = 1'b1;
    step(2);
    check_outs("glitch_resync", 1'b1, 1'b1, 1'b0, S_WAIT);
    step(1);
    check_outs("glitch_resettle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(LW - 1);
    check_outs("glitch_full_settle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(1);
    check_outs("glitch_core", 1'b0, 1'b1, 1'b0, S_CORE);
    step(SD);
    check_outs("glitch_run", 1'b0, 1'b0, 1'b1, S_RUN);

    // Reset pulsed at CORE count 2, checked asynchronously mid-cycle.
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(3);
    check_outs("mid_settle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(LW + 2);
    check_outs("mid_core2", 1'b0, 1'b1, 1'b0, S_CORE);
    #1 reset = 1'b1;
    #1;
    check_outs("mid_async", 1'b1, 1'b1, 1'b0, S_WAIT);
    step(2);
    reset = 1'b0;
    step(2);
    check_outs("mid_restart_sync", 1'b1, 1'b1, 1'b0, S_WAIT);
    step(1);
    check_outs("mid_restart_settle", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(LW - 1);
    check_outs("mid_settle_last", 1'b1, 1'b1, 1'b0, S_SETTLE);
    step(1);
    check_outs("mid_core", 1'b0, 1'b1, 1'b0, S_CORE);
    step(SD - 1);
    check_outs("mid_core_last", 1'b0, 1'b1, 1'b0, S_CORE);
    step(1);
    check_outs("mid_run", 1'b0, 1'b0, 1'b1, S_RUN);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
